// File: rtl/ft_tx_sched_if.sv
// Burst handshake bundle between the TX scheduler, the CPU packet path and the IQ FIFO/output mux.
// The slave modport is the scheduler side; the master modport is the environment side.
interface ft_tx_sched_if;
  logic [7:0]  cpu_wc_i;
  logic [10:0] fifo_level_i;
  logic        ft_done_i;
  logic        grant_cpu_o;
  logic        grant_fifo_o;
  logic [10:0] burst_len_o;
  logic [7:0]  cpu_wc_done_o;

  modport slave (
    input  cpu_wc_i, fifo_level_i, ft_done_i,
    output grant_cpu_o, grant_fifo_o, burst_len_o, cpu_wc_done_o
  );

  modport master (
    output cpu_wc_i, fifo_level_i, ft_done_i,
    input  grant_cpu_o, grant_fifo_o, burst_len_o, cpu_wc_done_o
  );
endinterface

// File: rtl/ft_tx_sched.sv
// TX burst scheduler: arbitrates CPU packets against fixed-size IQ bursts with starvation control.
// Optional grant watchdog is enabled by defining FT_TX_SCHED_TIMEOUT_EN.
module ft_tx_sched #(
  parameter int BURST_WORDS    = 1024,
  parameter int HIGH_WATER     = 1536,
  parameter int STARVE_MAX     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic         clk_i,
  input  logic         reset_n,
  input  logic         enable_i,
  ft_tx_sched_if.slave bus,
  output logic         busy_o,
  output logic         timeout_o,
  output logic [15:0]  iq_bursts_o
);

  typedef enum logic [1:0] {IDLE, GRANT_CPU, GRANT_FIFO, GAP} state_e;

  state_e      state_q, state_d;
  logic        grant_cpu_q, grant_cpu_d;
  logic        grant_fifo_q, grant_fifo_d;
  logic [10:0] burst_len_q, burst_len_d;
  logic [7:0]  cpu_wc_done_q, cpu_wc_done_d;
  logic        busy_q, busy_d;
  logic [15:0] iq_bursts_q, iq_bursts_d;
  logic [15:0] starve_q, starve_d;

  logic        cpu_pending_s, fifo_ready_s, fifo_urgent_s, starved_s;
  logic [7:0]  cpu_delta_s;

  // Modulo-256 difference lets the write counter wrap freely
  assign cpu_delta_s   = bus.cpu_wc_i - cpu_wc_done_q;
  assign cpu_pending_s = (bus.cpu_wc_i != cpu_wc_done_q);
  assign fifo_ready_s  = (32'(bus.fifo_level_i) >= BURST_WORDS);
  assign fifo_urgent_s = (32'(bus.fifo_level_i) >= HIGH_WATER);
  assign starved_s     = (32'(starve_q) >= STARVE_MAX);

`ifdef FT_TX_SCHED_TIMEOUT_EN
  logic        timeout_q, timeout_d;
  logic [15:0] wdog_q, wdog_d;
  logic        wdog_hit_s;

  assign wdog_hit_s = (32'(wdog_q) >= TIMEOUT_CYCLES - 1);
  assign timeout_o  = timeout_q;
`else
  assign timeout_o  = 1'b0;
`endif

  // Next-state and registered-output computation
  always_comb begin
    state_d       = state_q;
    grant_cpu_d   = grant_cpu_q;
    grant_fifo_d  = grant_fifo_q;
    burst_len_d   = burst_len_q;
    cpu_wc_done_d = cpu_wc_done_q;
    iq_bursts_d   = iq_bursts_q;
    starve_d      = starve_q;
`ifdef FT_TX_SCHED_TIMEOUT_EN
    timeout_d     = 1'b0;
    wdog_d        = 16'd0;
`endif
    case (state_q)
      IDLE: begin
        if (enable_i && cpu_pending_s && (!fifo_urgent_s || starved_s)) begin
          state_d       = GRANT_CPU;
          grant_cpu_d   = 1'b1;
          burst_len_d   = {3'b000, cpu_delta_s};
          cpu_wc_done_d = bus.cpu_wc_i;
          starve_d      = 16'd0;
        end else if (enable_i && fifo_ready_s) begin
          state_d      = GRANT_FIFO;
          grant_fifo_d = 1'b1;
          burst_len_d  = 11'(BURST_WORDS);
          iq_bursts_d  = iq_bursts_q + 16'd1;
          // Only bursts that jump ahead of a waiting CPU packet count toward starvation
          if (cpu_pending_s && !starved_s) begin
            starve_d = starve_q + 16'd1;
          end else begin
            starve_d = starve_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      GRANT_CPU, GRANT_FIFO: begin
        if (bus.ft_done_i) begin
          state_d      = GAP;
          grant_cpu_d  = 1'b0;
          grant_fifo_d = 1'b0;
        end
`ifdef FT_TX_SCHED_TIMEOUT_EN
        else if (wdog_hit_s) begin
          state_d      = GAP;
          grant_cpu_d  = 1'b0;
          grant_fifo_d = 1'b0;
          timeout_d    = 1'b1;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`else
        else begin
          state_d = state_q;
        end
`endif
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        grant_cpu_d  = 1'b0;
        grant_fifo_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_cpu_q   <= 1'b0;
      grant_fifo_q  <= 1'b0;
      burst_len_q   <= 11'd0;
      cpu_wc_done_q <= 8'd0;
      busy_q        <= 1'b0;
      iq_bursts_q   <= 16'd0;
      starve_q      <= 16'd0;
    end else begin
      state_q       <= state_d;
      grant_cpu_q   <= grant_cpu_d;
      grant_fifo_q  <= grant_fifo_d;
      burst_len_q   <= burst_len_d;
      cpu_wc_done_q <= cpu_wc_done_d;
      busy_q        <= busy_d;
      iq_bursts_q   <= iq_bursts_d;
      starve_q      <= starve_d;
    end
  end

`ifdef FT_TX_SCHED_TIMEOUT_EN
  // Grant watchdog registers
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
      wdog_q    <= 16'd0;
    end else begin
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end
`endif

  assign bus.grant_cpu_o   = grant_cpu_q;
  assign bus.grant_fifo_o  = grant_fifo_q;
  assign bus.burst_len_o   = burst_len_q;
  assign bus.cpu_wc_done_o = cpu_wc_done_q;
  assign busy_o            = busy_q;
  assign iq_bursts_o       = iq_bursts_q;

endmodule
